weight_mac_engine: RTL and testbench

Sequential multiply-accumulate engine that sits directly downstream of the weight RAM in the neuron datapath. It walks the RAM `N` weights per beat, multiplies each returned weight vector lane-wise with the matching slice of a held activation vector, and accumulates `NUM_IN` products into one neuron pre-activation. It presents the raw sum and a shifted, saturated, optionally ReLU'd 10-bit activation on a valid/ready output.

---
 rtl/weight_mac_engine.sv | 141 ++++++++++++++
 tb/tb_weight_mac_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_mac_engine.sv
`timescale 1ns/1ps
// Sequential dot-product engine: walks the weight RAM N lanes per beat, accumulates
// NUM_IN products against a held activation vector and presents Sum and a saturated Y.
module weight_mac_engine #(
    parameter int unsigned N         = 10,
    parameter int unsigned NUM_IN    = 60,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ACC_W     = 26,
    parameter int unsigned SHIFT     = 9,
    parameter int unsigned RELU      = 0
) (
    input  logic                    Clock,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic signed [9:0]       X [0:NUM_IN-1],
    input  logic signed [9:0]       Q [0:N-1],
    output logic [6:0]              Address,
    output logic                    WE,
    output logic                    Busy,
    output logic signed [ACC_W-1:0] Sum,
    output logic signed [9:0]       Y,
    output logic                    Valid,
    input  logic                    Ready
);

    localparam int unsigned C  = NUM_IN / N;
    localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned XW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(511);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-512);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state, state_n;
    logic [KW-1:0]           k;
    logic [KW-1:0]           q_k;
    logic                    q_v;
    logic                    drain_cnt;
    logic                    start_run;
    logic                    load_out;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [9:0]       y_c;

    assign WE = 1'b0;

    // State register
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state and control strobes
    always_comb begin
        state_n   = state;
        start_run = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_n   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (k == KW'(C - 1)) state_n = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_n  = DONE;
                    load_out = 1'b1;
                end
            end
            DONE: begin
                if (Ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane products for the chunk whose RAM data is currently on Q, summed as a chain
    for (genvar gi = 0; gi < int'(N); gi++) begin : g_lane
        logic [XW-1:0]           idx;
        logic signed [19:0]      prod;
        logic signed [ACC_W-1:0] ps;
        assign idx  = XW'(q_k * N + gi);
        assign prod = 20'(Q[gi]) * 20'(X[idx]);
        if (gi == 0) begin : g_first
            assign ps = ACC_W'(prod);
        end else begin : g_rest
            assign ps = g_lane[gi-1].ps + ACC_W'(prod);
        end
    end
    assign lane_sum = g_lane[N-1].ps;

    // Shift, saturate to 10 bits, optional ReLU
    always_comb begin
        shifted = acc >>> SHIFT;
        if (shifted > Y_MAX)      y_c = 10'sh1FF;
        else if (shifted < Y_MIN) y_c = 10'sh200;
        else                      y_c = 10'(shifted);
        if (RELU != 0 && y_c[9])  y_c = '0;
    end

    // Address issue, two-deep accumulate pipeline and result registers
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            Address   <= '0;
            Busy      <= 1'b0;
            Valid     <= 1'b0;
            Sum       <= '0;
            Y         <= '0;
            k         <= '0;
            q_k       <= '0;
            q_v       <= 1'b0;
            drain_cnt <= 1'b0;
            acc       <= '0;
        end else begin
            Busy      <= (state_n != IDLE);
            Valid     <= (state_n == DONE);
            q_v       <= (state == RUN);
            q_k       <= k;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (q_v) acc <= acc + lane_sum;
            if (start_run) begin
                k       <= '0;
                Address <= 7'(BASE_ADDR);
                acc     <= '0;
            end else if (state == RUN && k != KW'(C - 1)) begin
                k       <= k + KW'(1);
                Address <= Address + 7'(N);
            end
            if (load_out) begin
                Sum <= acc;
                Y   <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_weight_mac_engine.sv
`timescale 1ns/1ps
// Scoreboard bench: four engine configurations share X/Ready, each with its own RAM read port;
// directed runs push hand-computed results, a monitor pops on every Valid&Ready.
module tb_weight_mac_engine;

    localparam int unsigned NI = 4;
    localparam int unsigned LN = 10;
    localparam int unsigned NX = 60;
    localparam int unsigned AW = 26;
    localparam int          C  = 6;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;
    always #5 Clock = ~Clock;

    logic                 start [NI];
    logic                 rdy;
    logic signed [9:0]    x [0:NX-1];
    logic signed [9:0]    w [0:74];
    logic [6:0]           addr  [NI];
    logic                 we    [NI];
    logic                 busy  [NI];
    logic                 valid [NI];
    logic signed [AW-1:0] sum   [NI];
    logic signed [9:0]    y     [NI];

    typedef struct {
        int                   g;
        logic signed [AW-1:0] s;
        logic signed [9:0]    y;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // g0: SHIFT=0; g1: SHIFT=0 RELU=1; g2: SHIFT=0 BASE_ADDR=3; g3: defaults
    for (genvar g = 0; g < int'(NI); g++) begin : g_dut
        logic signed [9:0] q [0:LN-1];
        always @(posedge Clock)
            for (int i = 0; i < int'(LN); i++) q[i] <= w[int'(addr[g]) + i];
        weight_mac_engine #(
            .N(LN), .NUM_IN(NX), .BASE_ADDR((g == 2) ? 3 : 0), .ACC_W(AW),
            .SHIFT((g == 3) ? 9 : 0), .RELU((g == 1) ? 1 : 0)
        ) u_dut (
            .Clock(Clock), .Rst(Rst), .Start(start[g]), .X(x), .Q(q),
            .Address(addr[g]), .WE(we[g]), .Busy(busy[g]), .Sum(sum[g]),
            .Y(y[g]), .Valid(valid[g]), .Ready(rdy)
        );
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int wv, input int xv);
        for (int i = 0; i < 75; i++) w[i] = 10'(wv);
        for (int j = 0; j < int'(NX); j++) x[j] = 10'(xv);
    endtask

    // Start one run on instance g, checking address issue and the Valid edge at E0+C+2
    task automatic run(input int g, input int base, input logic signed [AW-1:0] es,
                       input logic signed [9:0] ey);
        exp_t e;
        e.g = g; e.s = es; e.y = ey;
        sb.push_back(e);
        @(negedge Clock);
        start[g] = 1'b1;
        @(posedge Clock);
        for (int ed = 0; ed <= C + 2; ed++) begin
            @(negedge Clock);
            start[g] = 1'b0;
            if (ed < C) begin
                chk("address", addr[g], base + 10 * ed);
                chk("we_zero", we[g], 0);
                chk("busy_run", busy[g], 1);
            end
            if (ed == C + 1) chk("valid_early", valid[g], 0);
            if (ed == C + 2) chk("valid_latency", valid[g], 1);
            if (ed < C + 2) @(posedge Clock);
        end
    endtask

    task automatic idle_chk(input int g);
        @(negedge Clock);
        chk("busy_after_take", busy[g], 0);
        chk("valid_after_take", valid[g], 0);
        @(negedge Clock);
    endtask

    // Monitor: pop and compare whenever a result is handed off
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            #1;
            for (int g = 0; g < int'(NI); g++) begin
                if (Rst && valid[g] && rdy) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: inst=%0d sum=%0d y=%0d", g, sum[g], y[g]);
                    end else begin
                        e = sb.pop_front();
                        chk("result_inst", g, e.g);
                        chk("result_sum", sum[g], e.s);
                        chk("result_y", y[g], e.y);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy = 1'b1;
        for (int g = 0; g < int'(NI); g++) start[g] = 1'b0;
        fill(0, 0);
        repeat (3) @(negedge Clock);
        for (int g = 0; g < int'(NI); g++) begin
            chk("rst_address", addr[g], 0);
            chk("rst_we", we[g], 0);
            chk("rst_busy", busy[g], 0);
            chk("rst_valid", valid[g], 0);
            chk("rst_sum", sum[g], 0);
            chk("rst_y", y[g], 0);
        end
        Rst = 1'b1;
        @(negedge Clock);

        fill(1, 1);
        run(0, 0, 60, 60);
        idle_chk(0);

        fill(-1, 5);
        run(0, 0, -300, -300);
        idle_chk(0);
        run(1, 0, -300, 0);
        idle_chk(1);

        for (int a = 0; a < 75; a++) w[a] = 10'(a - 3);
        for (int j = 0; j < int'(NX); j++) x[j] = 10'(j);
        run(2, 3, 70210, 511);
        idle_chk(2);

        fill(511, 511);
        run(3, 0, 15667260, 511);
        idle_chk(3);

        // Backpressure with a Start pulse while the result is held
        fill(511, -512);
        rdy = 1'b0;
        run(3, 0, -15697920, -512);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            start[3] = (c == 1);
            #1;
            chk("hold_valid", valid[3], 1);
            chk("hold_sum", sum[3], -15697920);
            chk("hold_y", y[3], -512);
            chk("hold_busy", busy[3], 1);
        end
        @(negedge Clock);
        rdy = 1'b1;
        @(negedge Clock);
        chk("release_valid", valid[3], 0);
        chk("release_busy", busy[3], 0);
        repeat (3) begin
            @(negedge Clock);
            chk("no_queued_start", busy[3], 0);
        end

        // Reset asserted at E0+3 of a run
        fill(3, 7);
        @(negedge Clock);
        start[3] = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start[3] = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        Rst = 1'b0;
        #1;
        chk("midrst_address", addr[3], 0);
        chk("midrst_busy", busy[3], 0);
        chk("midrst_valid", valid[3], 0);
        chk("midrst_sum", sum[3], 0);
        chk("midrst_y", y[3], 0);
        chk("midrst_we", we[3], 0);
        @(negedge Clock);
        Rst = 1'b1;
        @(negedge Clock);
        fill(511, 511);
        run(3, 0, 15667260, 511);
        idle_chk(3);

        @(negedge Clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
